rptr_empty_lvl: RTL

Read-side pointer and status block for the dual-clock FIFO, the parametrised successor to the basic read-pointer/empty logic. It keeps the binary and Gray read pointers in the read clock domain and generates registered empty status against the synchronised write pointer. It adds a fill-level count, a programmable almost-empty flag and an optional sticky underflow flag. It sits between the read-domain 2-FF synchroniser (`rq2_wptr`) and the FIFO memory read address, and returns `rptr` to the write-domain synchroniser.

---
 rtl/rptr_empty_lvl.sv | 83 ++++++++
 1 files changed

// File: rtl/rptr_empty_lvl.sv
// Read-side pointer, empty, fill-level and almost-empty status for a dual-clock FIFO.
// Optional sticky underflow flag is built only when RPTR_UNDERFLOW_EN is defined.
module rptr_empty_lvl #(
  parameter int                ADDRSIZE = 4,
  parameter logic [ADDRSIZE:0] AE_RST   = {{ADDRSIZE{1'b0}}, 1'b1}
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic                ae_wr,
  input  logic [ADDRSIZE:0]   ae_thresh,
  input  logic                rerr_clr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                rerr
);

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbinnext;
  logic [ADDRSIZE:0] rgraynext;
  logic [ADDRSIZE:0] wbin_s;
  logic [ADDRSIZE:0] lvl_next;
  logic [ADDRSIZE:0] ae_reg;
  logic              rd_ok;

  assign rd_ok     = rinc & ~rempty;
  assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, rd_ok};
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;
  assign raddr     = rbin[ADDRSIZE-1:0];

  // Gray to binary: each bit is the XOR of the Gray word from that bit up to the MSB.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin_s[i] = ^(rq2_wptr >> i);
    end
  end

  assign lvl_next = wbin_s - rbinnext;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin    <= '0;
      rptr    <= '0;
      rlevel  <= '0;
      rempty  <= 1'b1;
      raempty <= 1'b1;
      ae_reg  <= AE_RST;
    end else begin
      rbin    <= rbinnext;
      rptr    <= rgraynext;
      rlevel  <= lvl_next;
      rempty  <= (rgraynext == rq2_wptr);
      // Uses the threshold held before this edge, so a new value acts one cycle later.
      raempty <= (lvl_next <= ae_reg);
      if (ae_wr) begin
        ae_reg <= ae_thresh;
      end
    end
  end

`ifdef RPTR_UNDERFLOW_EN
  // Sticky underflow: a new blocked read wins over a clear in the same cycle.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rerr <= 1'b0;
    end else if (rinc & rempty) begin
      rerr <= 1'b1;
    end else if (rerr_clr) begin
      rerr <= 1'b0;
    end
  end
`else
  logic unused_rerr_clr;
  assign unused_rerr_clr = rerr_clr;
  assign rerr            = 1'b0;
`endif

endmodule
